button_conditioner: RTL and testbench

- Input-side counterpart to the board's LED/seven-segment output logic: conditions raw mechanical inputs (btnc/btnu/btnl/btnr/btnd, optionally sw) before any logic consumes them.
- Per channel: 2-FF synchronizer, counter-based debounce, one-cycle press/release pulses, and a typematic auto-repeat pulse while a button is held.
- Sits directly behind the top-level pins; all downstream logic uses its outputs, never raw pins.

---
 rtl/button_conditioner_pkg.sv | 19 +
 rtl/button_conditioner_channel.sv | 118 +++++++++++
 rtl/button_conditioner.sv | 46 ++++
 tb/tb_button_conditioner.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner: repeat FSM encoding and
// default 100 MHz timing constants.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE  = 2'd0,
    RPT_DELAY = 2'd1,
    RPT_RUN   = 2'd2
  } rpt_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 50_000_000; // 500 ms
  localparam int unsigned DEF_REPEAT_RATE     = 10_000_000; // 100 ms

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One input channel: 2-FF synchronizer, counter debounce, edge pulses and
// typematic auto-repeat.
//
// state     | meaning
// RPT_IDLE  | released, waiting for a debounced press
// RPT_DELAY | held, counting the initial repeat delay
// RPT_RUN   | held, emitting a pulse every repeat period
module button_conditioner_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic clk100mhz,
  input  logic cpu_resetn,
  input  logic raw,
  output logic level,
  output logic level_nxt,
  output logic press,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int RW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE));
  localparam logic [DW-1:0] DEB_TC   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_TC = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_TC  = RW'(REPEAT_RATE - 1);

  logic          s1, s2;
  logic [DW-1:0] dcnt;
  logic          change, deb_tc, rise, fall;

  rpt_state_t    state, state_nxt;
  logic [RW-1:0] rcnt, rcnt_nxt;
  logic          rpt_nxt;

  assign change    = s2 ^ level;
  assign deb_tc    = change && (dcnt == DEB_TC);
  assign rise      = deb_tc && s2;
  assign fall      = deb_tc && !s2;
  assign level_nxt = deb_tc ? s2 : level;

  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      level         <= 1'b0;
      press         <= 1'b0;
      release_pulse <= 1'b0;
      dcnt          <= '0;
    end else begin
      s1            <= raw;
      s2            <= s1;
      level         <= level_nxt;
      press         <= rise;
      release_pulse <= fall;
      // any return to the accepted level restarts the stability count
      if (!change || deb_tc) dcnt <= '0;
      else                   dcnt <= dcnt + DW'(1);
    end
  end

  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state        <= RPT_IDLE;
      rcnt         <= '0;
      repeat_pulse <= 1'b0;
    end else begin
      state        <= state_nxt;
      rcnt         <= rcnt_nxt;
      repeat_pulse <= rpt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rcnt_nxt  = rcnt;
    rpt_nxt   = 1'b0;
    // release wins over a repeat terminal count on the same edge
    if (fall) begin
      state_nxt = RPT_IDLE;
      rcnt_nxt  = '0;
    end else begin
      unique case (state)
        RPT_IDLE: begin
          if (rise) begin
            state_nxt = RPT_DELAY;
            rcnt_nxt  = '0;
          end
        end
        RPT_DELAY: begin
          if (rcnt == DELAY_TC) begin
            rpt_nxt   = 1'b1;
            rcnt_nxt  = '0;
            state_nxt = RPT_RUN;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        RPT_RUN: begin
          if (rcnt == RATE_TC) begin
            rpt_nxt  = 1'b1;
            rcnt_nxt = '0;
          end else begin
            rcnt_nxt = rcnt + RW'(1);
          end
        end
        default: begin
          state_nxt = RPT_IDLE;
          rcnt_nxt  = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Conditions raw board buttons/switches into debounced levels and pulses.
// release/repeat are keywords, hence the release_pulse/repeat_pulse names.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned W               = 5,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE
) (
  input  logic         clk100mhz,
  input  logic         cpu_resetn,
  input  logic [W-1:0] raw,
  output logic [W-1:0] level,
  output logic [W-1:0] press,
  output logic [W-1:0] release_pulse,
  output logic [W-1:0] repeat_pulse,
  output logic         any_held
);

  logic [W-1:0] level_nxt;

  for (genvar i = 0; i < W; i++) begin : g_ch
    button_conditioner_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_ch (
      .clk100mhz     (clk100mhz),
      .cpu_resetn    (cpu_resetn),
      .raw           (raw[i]),
      .level         (level[i]),
      .level_nxt     (level_nxt[i]),
      .press         (press[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i])
    );
  end

  // built from next-level so it lines up with the registered level bits
  always_ff @(posedge clk100mhz or negedge cpu_resetn) begin
    if (!cpu_resetn) any_held <= 1'b0;
    else             any_held <= |level_nxt;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with an event scoreboard keyed by
// clock edge (W=2, DEBOUNCE=4, REPEAT_DELAY=10, REPEAT_RATE=3).
module tb_button_conditioner;

  localparam int LAT   = 6;  // raw change to level update: 2 sync + 4 debounce
  localparam int RDLY  = 10;
  localparam int RRATE = 3;
  localparam int K_PRESS = 0, K_REL = 1, K_RPT = 2;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  logic       clk100mhz = 1'b0;
  logic       cpu_resetn;
  logic [1:0] raw;
  logic [1:0] level, press, release_pulse, repeat_pulse;
  logic       any_held;

  ev_t        q[$];
  logic [1:0] exp_level;
  int         cyc;
  int         n_chk  = 0;
  int         n_pass = 0;

  button_conditioner #(
    .W(2), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(RDLY), .REPEAT_RATE(RRATE)
  ) dut (
    .clk100mhz     (clk100mhz),
    .cpu_resetn    (cpu_resetn),
    .raw           (raw),
    .level         (level),
    .press         (press),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_held      (any_held)
  );

  always #5 clk100mhz = ~clk100mhz;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
  endtask

  task automatic check_cycle();
    logic [1:0] ep, er, et;
    ev_t nq[$];
    ep = '0; er = '0; et = '0;
    foreach (q[i]) begin
      if (q[i].cyc == cyc) begin
        case (q[i].kind)
          K_PRESS: ep[q[i].ch] = 1'b1;
          K_REL:   er[q[i].ch] = 1'b1;
          default: et[q[i].ch] = 1'b1;
        endcase
      end else if (q[i].cyc > cyc) begin
        nq.push_back(q[i]);
      end
    end
    q = nq;
    exp_level = (exp_level | ep) & ~er;
    chk("level",    level,         exp_level);
    chk("press",    press,         ep);
    chk("release",  release_pulse, er);
    chk("repeat",   repeat_pulse,  et);
    chk("any_held", {1'b0, any_held}, {1'b0, |exp_level});
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk100mhz);
      check_cycle();
      @(posedge clk100mhz);
      cyc++;
      #2;
    end
  endtask

  // Raise a button: expect press after LAT edges and a long repeat train,
  // trimmed later by btn_off.
  task automatic btn_on(input int ch);
    int p;
    raw[ch] = 1'b1;
    p = cyc + LAT;
    q.push_back('{p, ch, K_PRESS});
    for (int k = 0; k < 60; k++) q.push_back('{p + RDLY + k * RRATE, ch, K_RPT});
  endtask

  task automatic btn_off(input int ch);
    int r;
    ev_t nq[$];
    raw[ch] = 1'b0;
    r = cyc + LAT;
    foreach (q[i])
      if (!(q[i].ch == ch && q[i].kind == K_RPT && q[i].cyc >= r)) nq.push_back(q[i]);
    q = nq;
    q.push_back('{r, ch, K_REL});
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   level,         2'b00);
    chk({tag, "_press"},   press,         2'b00);
    chk({tag, "_release"}, release_pulse, 2'b00);
    chk({tag, "_repeat"},  repeat_pulse,  2'b00);
    chk({tag, "_any"},     {1'b0, any_held}, 2'b00);
  endtask

  initial begin
    raw        = 2'b00;
    cpu_resetn = 1'b0;
    exp_level  = 2'b00;
    cyc        = 0;
    repeat (3) @(posedge clk100mhz);
    #2;
    chk_all_zero("reset");
    cpu_resetn = 1'b1;
    tick(5);

    // glitch of 3 cycles is rejected
    raw[0] = 1'b1; tick(3);
    raw[0] = 1'b0; tick(12);

    // bounce 1,1,0 then steady 1: single press LAT after the last rise
    raw[0] = 1'b1; tick(2);
    raw[0] = 1'b0; tick(1);
    btn_on(0);     tick(30);
    btn_off(0);    tick(12);

    // clean short press, released before first repeat
    btn_on(0);  tick(8);
    btn_off(0); tick(12);

    // auto-repeat on channel 1
    btn_on(1);  tick(24);
    btn_off(1); tick(15);

    // release update lands on the repeat terminal count (P+13)
    btn_on(0);  tick(RDLY + RRATE);
    btn_off(0); tick(12);

    // simultaneous channels, then release only ch0
    btn_on(0); btn_on(1); tick(20);
    btn_off(0); tick(15);
    btn_off(1); tick(12);

    // reset in the middle of a repeating hold
    btn_on(0); tick(22);
    cpu_resetn = 1'b0;
    #1;
    chk_all_zero("reset_async");
    q.delete();
    exp_level = 2'b00;
    tick(3);
    cpu_resetn = 1'b1;
    btn_on(0);  tick(25);
    btn_off(0); tick(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
